periph_router: RTL and testbench

Single-outstanding memory-bus target controller between the cpu/imem-dmem arbiter and the bram/print/clint slaves. It registers and decodes each request, issues a one-cycle valid to the selected slave with a base-relative address, waits for that slave's ready, and returns a registered response with error reporting.

---
 rtl/periph_router_if.sv | 24 ++
 rtl/periph_router.sv | 192 +++++++++++++++++++
 tb/tb_periph_router.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/periph_router_if.sv
// periph_router_if: request/response bus between the cpu-side arbiter and periph_router.
//   memory_valid/instr/addr/wdata/wstrb : request from the arbiter (wstrb == 0 means read)
//   memory_rdata/ready/error            : one-cycle registered response from the router
// Modports: master = arbiter side, slave = router side.
interface periph_router_if;
  logic        memory_valid;
  logic        memory_instr;
  logic [31:0] memory_addr;
  logic [31:0] memory_wdata;
  logic [3:0]  memory_wstrb;
  logic [31:0] memory_rdata;
  logic        memory_ready;
  logic        memory_error;

  modport master (
    output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    input  memory_rdata, memory_ready, memory_error
  );

  modport slave (
    input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    output memory_rdata, memory_ready, memory_error
  );
endinterface

// File: rtl/periph_router.sv
// periph_router: single-outstanding bus target that decodes a request to the bram, print or
// clint slave, issues a one-cycle valid with a region-relative address, waits for the slave's
// ready and returns a registered one-cycle response. Unmapped addresses answer with error.
// Ports:
//   clock, reset (async, active low)
//   bus      : periph_router_if.slave, request in / response out
//   slv_*    : registered request fields shared by all slaves (slv_addr is base-relative)
//   <s>_valid/<s>_rdata/<s>_ready for s in {bram, print, clint}
// Optional build macro: PERIPH_TIMEOUT_EN bounds the WAIT state to TIMEOUT_CYCLES cycles and
// then answers with error; without it WAIT is unbounded.
module periph_router #(
  parameter logic [31:0] BRAM_BASE      = 32'h0000_0000,
  parameter logic [31:0] BRAM_SIZE      = 32'h0010_0000,
  parameter logic [31:0] PRINT_BASE     = 32'h0100_0000,
  parameter logic [31:0] PRINT_SIZE     = 32'h0000_1000,
  parameter logic [31:0] CLINT_BASE     = 32'h0200_0000,
  parameter logic [31:0] CLINT_SIZE     = 32'h000C_0000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clock,
  input  logic              reset,
  periph_router_if.slave    bus,
  output logic              slv_instr,
  output logic [31:0]       slv_addr,
  output logic [31:0]       slv_wdata,
  output logic [3:0]        slv_wstrb,
  output logic              bram_valid,
  input  logic [31:0]       bram_rdata,
  input  logic              bram_ready,
  output logic              print_valid,
  input  logic [31:0]       print_rdata,
  input  logic              print_ready,
  output logic              clint_valid,
  input  logic [31:0]       clint_rdata,
  input  logic              clint_ready
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
  typedef enum logic [1:0] {TgtNone, TgtBram, TgtPrint, TgtClint} target_e;

  // 33-bit compare so a region ending at 2^32 cannot wrap.
  function automatic logic in_region(logic [31:0] a, logic [31:0] base, logic [31:0] size);
    return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < ({1'b0, base} + {1'b0, size}));
  endfunction

  state_e      state_q, state_d;
  target_e     target_q, target_d;
  logic        slv_instr_q, slv_instr_d;
  logic [31:0] slv_addr_q, slv_addr_d;
  logic [31:0] slv_wdata_q, slv_wdata_d;
  logic [3:0]  slv_wstrb_q, slv_wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        ready_q, ready_d;
  logic        sel_ready;
  logic [31:0] sel_rdata;

`ifdef PERIPH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // Only the registered target's handshake is ever looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    unique case (target_q)
      TgtBram:  begin sel_ready = bram_ready;  sel_rdata = bram_rdata;  end
      TgtPrint: begin sel_ready = print_ready; sel_rdata = print_rdata; end
      TgtClint: begin sel_ready = clint_ready; sel_rdata = clint_rdata; end
      default:  ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    slv_instr_d = slv_instr_q;
    slv_addr_d  = slv_addr_q;
    slv_wdata_d = slv_wdata_q;
    slv_wstrb_d = slv_wstrb_q;
    rdata_d     = rdata_q;
    error_d     = error_q;
    ready_d     = 1'b0;
`ifdef PERIPH_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        // ready_q guards against re-accepting a request held high through its own response.
        if (bus.memory_valid && !ready_q) begin
          slv_instr_d = bus.memory_instr;
          slv_wdata_d = bus.memory_wdata;
          slv_wstrb_d = bus.memory_wstrb;
          rdata_d     = '0;
          error_d     = 1'b0;
          state_d     = StIssue;
          if (in_region(bus.memory_addr, CLINT_BASE, CLINT_SIZE)) begin
            target_d   = TgtClint;
            slv_addr_d = bus.memory_addr - CLINT_BASE;
          end else if (in_region(bus.memory_addr, PRINT_BASE, PRINT_SIZE)) begin
            target_d   = TgtPrint;
            slv_addr_d = bus.memory_addr - PRINT_BASE;
          end else if (in_region(bus.memory_addr, BRAM_BASE, BRAM_SIZE)) begin
            target_d   = TgtBram;
            slv_addr_d = bus.memory_addr - BRAM_BASE;
          end else begin
            target_d   = TgtNone;
            slv_addr_d = '0;
            error_d    = 1'b1;
            state_d    = StResp;
          end
        end
      end
      StIssue: begin
`ifdef PERIPH_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (sel_ready) begin
          rdata_d = sel_rdata;
          state_d = StResp;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (sel_ready) begin
          rdata_d = sel_rdata;
          state_d = StResp;
        end
`ifdef PERIPH_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          error_d = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      StResp: begin
        ready_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      target_q    <= TgtNone;
      slv_instr_q <= 1'b0;
      slv_addr_q  <= '0;
      slv_wdata_q <= '0;
      slv_wstrb_q <= '0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
      ready_q     <= 1'b0;
`ifdef PERIPH_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      slv_instr_q <= slv_instr_d;
      slv_addr_q  <= slv_addr_d;
      slv_wdata_q <= slv_wdata_d;
      slv_wstrb_q <= slv_wstrb_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
      ready_q     <= ready_d;
`ifdef PERIPH_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign slv_instr   = slv_instr_q;
  assign slv_addr    = slv_addr_q;
  assign slv_wdata   = slv_wdata_q;
  assign slv_wstrb   = slv_wstrb_q;
  assign bram_valid  = (state_q == StIssue) && (target_q == TgtBram);
  assign print_valid = (state_q == StIssue) && (target_q == TgtPrint);
  assign clint_valid = (state_q == StIssue) && (target_q == TgtClint);

  // Response fields read as zero outside the ready pulse.
  assign bus.memory_ready = ready_q;
  assign bus.memory_rdata = ready_q ? rdata_q : '0;
  assign bus.memory_error = ready_q & error_q;

endmodule

// File: tb/tb_periph_router.sv
// Self-checking bench for periph_router: directed and random transactions checked cycle by
// cycle against a region-table model of decode and response timing.
module tb_periph_router;

`ifdef PERIPH_TIMEOUT_EN
  localparam int unsigned TbTimeout = 8;
  localparam bit          ToEn      = 1'b1;
`else
  localparam int unsigned TbTimeout = 256;
  localparam bit          ToEn      = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        slv_instr;
  logic [31:0] slv_addr;
  logic [31:0] slv_wdata;
  logic [3:0]  slv_wstrb;
  logic        bram_valid, print_valid, clint_valid;
  logic [31:0] bram_rdata, print_rdata, clint_rdata;
  logic        bram_ready, print_ready, clint_ready;

  int checks = 0;
  int errors = 0;

  // Region table in decode priority order: 0 = clint, 1 = print, 2 = bram; 3 = unmapped.
  longint unsigned reg_base [3] = '{64'h0200_0000, 64'h0100_0000, 64'h0000_0000};
  longint unsigned reg_size [3] = '{64'h000C_0000, 64'h0000_1000, 64'h0010_0000};

  periph_router_if bus ();

  periph_router #(
    .TIMEOUT_CYCLES(TbTimeout)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .slv_instr  (slv_instr),
    .slv_addr   (slv_addr),
    .slv_wdata  (slv_wdata),
    .slv_wstrb  (slv_wstrb),
    .bram_valid (bram_valid),
    .bram_rdata (bram_rdata),
    .bram_ready (bram_ready),
    .print_valid(print_valid),
    .print_rdata(print_rdata),
    .print_ready(print_ready),
    .clint_valid(clint_valid),
    .clint_rdata(clint_rdata),
    .clint_ready(clint_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void decode(input logic [31:0] a, output int tgt, output logic [31:0] off);
    longint unsigned la;
    la  = 64'(a);
    tgt = 3;
    off = '0;
    for (int r = 0; r < 3; r++) begin
      if (tgt == 3 && la >= reg_base[r] && la < reg_base[r] + reg_size[r]) begin
        tgt = r;
        off = 32'(la - reg_base[r]);
      end
    end
  endfunction

  task automatic clear_slaves();
    bram_ready  = 1'b0;
    print_ready = 1'b0;
    clint_ready = 1'b0;
    bram_rdata  = '0;
    print_rdata = '0;
    clint_rdata = '0;
  endtask

  // Cycle idx counts posedges from the accepting edge; the target answers in cycle dly+1.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr,
                         input int unsigned dly, input logic [31:0] rd);
    int          tgt;
    logic [31:0] off;
    int unsigned last;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [2:0]  exp_v;
    logic        hit;
    decode(addr, tgt, off);
    if (tgt == 3) begin
      last = 2; exp_rd = '0; exp_err = 1'b1;
    end else if (ToEn && dly > TbTimeout) begin
      last = TbTimeout + 3; exp_rd = '0; exp_err = 1'b1;
    end else begin
      last = dly + 3; exp_rd = rd; exp_err = 1'b0;
    end
    @(negedge clock);
    bus.memory_valid = 1'b1;
    bus.memory_addr  = addr;
    bus.memory_wdata = wdata;
    bus.memory_wstrb = wstrb;
    bus.memory_instr = instr;
    for (int unsigned idx = 1; idx <= last + 1; idx++) begin
      @(negedge clock);
      exp_v = (tgt != 3 && idx == 1) ? (3'b100 >> tgt) : 3'b000;
      chk("valids", {29'b0, clint_valid, print_valid, bram_valid}, {29'b0, exp_v});
      chk("ready", {31'b0, bus.memory_ready}, {31'b0, idx == last});
      chk("rdata", bus.memory_rdata, (idx == last) ? exp_rd : 32'h0);
      chk("error", {31'b0, bus.memory_error}, {31'b0, (idx == last) ? exp_err : 1'b0});
      if (idx == 1 && tgt != 3) begin
        chk("slv_addr", slv_addr, off);
        chk("slv_wdata", slv_wdata, wdata);
        chk("slv_wstrb", {28'b0, slv_wstrb}, {28'b0, wstrb});
        chk("slv_instr", {31'b0, slv_instr}, {31'b0, instr});
      end
      if (idx == last) bus.memory_valid = 1'b0;
      // Non-target slaves chatter randomly; the target answers only in its slot.
      bram_ready  = 1'($urandom_range(0, 1));
      print_ready = 1'($urandom_range(0, 1));
      clint_ready = 1'($urandom_range(0, 1));
      bram_rdata  = $urandom;
      print_rdata = $urandom;
      clint_rdata = $urandom;
      hit = (idx == dly + 1);
      case (tgt)
        0: begin clint_ready = hit; if (hit) clint_rdata = rd; end
        1: begin print_ready = hit; if (hit) print_rdata = rd; end
        2: begin bram_ready  = hit; if (hit) bram_rdata  = rd; end
        default: ;
      endcase
    end
    clear_slaves();
  endtask

  initial begin
    logic [31:0] addr;
    int          r;
    int          mode;
    reset            = 1'b0;
    bus.memory_valid = 1'b0;
    bus.memory_instr = 1'b0;
    bus.memory_addr  = '0;
    bus.memory_wdata = '0;
    bus.memory_wstrb = '0;
    clear_slaves();
    @(negedge clock);
    @(negedge clock);
    chk("rst_ready", {31'b0, bus.memory_ready}, 32'h0);
    chk("rst_rdata", bus.memory_rdata, 32'h0);
    chk("rst_error", {31'b0, bus.memory_error}, 32'h0);
    chk("rst_valids", {29'b0, clint_valid, print_valid, bram_valid}, 32'h0);
    chk("rst_slv_addr", slv_addr, 32'h0);
    chk("rst_slv_wstrb", {28'b0, slv_wstrb}, 32'h0);
    reset = 1'b1;

    // Directed cases and region boundaries.
    run_txn(32'h0000_0010, 32'h0,        4'b0000, 1'b0, 1, 32'hDEAD_BEEF);
    run_txn(32'h0100_0000, 32'h41,       4'b0001, 1'b0, 0, 32'h0000_0055);
    run_txn(32'h0200_BFF8, 32'h0,        4'b0000, 1'b0, 5, 32'h1234_5678);
    run_txn(32'h0300_0000, 32'h77,       4'b1111, 1'b0, 0, 32'hFFFF_FFFF);
    run_txn(32'h000F_FFFC, 32'hA5A5_5A5A, 4'b1100, 1'b1, 2, 32'hCAFE_0001);
    run_txn(32'h0010_0000, 32'h0,        4'b0000, 1'b0, 0, 32'h1);
    run_txn(32'h0100_0FFF, 32'h0,        4'b0000, 1'b0, 3, 32'h0BAD_F00D);
    run_txn(32'h0100_1000, 32'h0,        4'b0000, 1'b0, 0, 32'h2);
    run_txn(32'h0200_0000, 32'h0,        4'b0000, 1'b1, 0, 32'h0000_1111);
    run_txn(32'h020B_FFFF, 32'h0,        4'b0000, 1'b0, 4, 32'h2222_0000);
    run_txn(32'h020C_0000, 32'h0,        4'b0000, 1'b0, 0, 32'h3);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 3);
      if (r < 3) begin
        mode = $urandom_range(0, 3);
        if (mode == 0)      addr = 32'(reg_base[r]);
        else if (mode == 1) addr = 32'(reg_base[r] + reg_size[r] - 1);
        else                addr = 32'(reg_base[r] + ($urandom % reg_size[r]));
      end else begin
        addr = {8'($urandom_range(3, 255)), 24'($urandom)};
      end
      run_txn(addr, $urandom, 4'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(0, 6), $urandom);
    end

    // Reset while waiting on bram; a late ready must not produce a response.
    @(negedge clock);
    bus.memory_valid = 1'b1;
    bus.memory_addr  = 32'h0000_0080;
    bus.memory_wstrb = 4'b0000;
    @(negedge clock);
    chk("rw_bram_valid", {31'b0, bram_valid}, 32'h1);
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rw_ready", {31'b0, bus.memory_ready}, 32'h0);
    chk("rw_valids", {29'b0, clint_valid, print_valid, bram_valid}, 32'h0);
    chk("rw_slv_addr", slv_addr, 32'h0);
    chk("rw_rdata", bus.memory_rdata, 32'h0);
    bus.memory_valid = 1'b0;
    @(negedge clock);
    reset      = 1'b1;
    bram_ready = 1'b1;
    bram_rdata = 32'h5555_AAAA;
    @(negedge clock);
    clear_slaves();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("rw_no_resp", {31'b0, bus.memory_ready}, 32'h0);
      chk("rw_no_valid", {29'b0, clint_valid, print_valid, bram_valid}, 32'h0);
    end

`ifdef PERIPH_TIMEOUT_EN
    // Silent slave: error after TbTimeout WAIT cycles, and a stray ready afterwards is ignored.
    run_txn(32'h0000_0100, 32'h0, 4'b0000, 1'b0, TbTimeout + 2, 32'h9999_9999);
    run_txn(32'h0100_0010, 32'h0, 4'b0000, 1'b0, TbTimeout, 32'h8888_0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
